// File: rtl/rival_car_gen.sv
// Rival car spawner/driver with player overlap detection and pass counter.
// Optional RIVAL_SPEEDUP_EN: step grows by 1 px every 8 rivals passed, capped at 4.
module rival_car_gen #(
    parameter int          OFFSET_BG_X   = 200,
    parameter int          OFFSET_BG_Y   = 150,
    parameter int          BG_HEIGHT     = 240,
    parameter int          CAR_WIDTH     = 14,
    parameter int          CAR_HEIGHT    = 16,
    parameter int          ROAD_LEFT     = 44,
    parameter int          RIVAL_STEP    = 2,
    parameter int          STEP_DIV      = 1_000_000,
    parameter int          RESPAWN_DELAY = 32,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        restart,
    input  logic [9:0]  car_x,
    input  logic [8:0]  car_y,
    input  logic        bg_sp_y,
    output logic [9:0]  rival_x,
    output logic [8:0]  rival_y,
    output logic        rival_active,
    output logic        collide_with_rival,
    output logic [15:0] score
);

    localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int DW = $clog2(RESPAWN_DELAY + 1);
    localparam logic [8:0]  SPAWN_Y   = 9'(OFFSET_BG_Y);
    localparam logic [9:0]  EXIT_Y    = 10'(OFFSET_BG_Y + BG_HEIGHT);
    localparam logic [9:0]  LANE_BASE = 10'(OFFSET_BG_X + ROAD_LEFT);
    localparam logic [10:0] CW        = 11'(CAR_WIDTH);
    localparam logic [10:0] CH        = 11'(CAR_HEIGHT);

    typedef enum logic [1:0] {
        S_WAIT,
        S_SPAWN,
        S_DRIVE,
        S_CRASH
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_tick_cnt;
    logic [DW-1:0]   r_delay;
    logic [15:0]     r_lfsr;

    logic            w_tick;
    logic            w_fb;
    logic [9:0]      w_lane_x;
    logic [9:0]      w_step;
    logic [9:0]      w_next_y;
    logic            w_exit;
    logic            w_overlap;

    assign w_tick = (r_tick_cnt == TW'(STEP_DIV - 1));
    assign w_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Lane 1 is weighted double so the centre lane appears most often.
    always_comb begin
        w_lane_x = LANE_BASE + 10'd30;
        unique case (r_lfsr[1:0])
            2'd0:    w_lane_x = LANE_BASE + 10'd4;
            2'd2:    w_lane_x = LANE_BASE + 10'd56;
            default: w_lane_x = LANE_BASE + 10'd30;
        endcase
    end

`ifdef RIVAL_SPEEDUP_EN
    logic [15:0] w_sum;
    assign w_sum  = 16'(RIVAL_STEP) + {3'b000, score[15:3]};
    assign w_step = (w_sum > 16'd4) ? 10'd4 : w_sum[9:0];
`else
    assign w_step = 10'(RIVAL_STEP);
`endif

    assign w_next_y = {1'b0, rival_y} + w_step;
    assign w_exit   = (w_next_y >= EXIT_Y);

    assign w_overlap = (r_state == S_DRIVE)
        && ({1'b0, rival_x} < {1'b0, car_x} + CW)
        && ({1'b0, car_x} < {1'b0, rival_x} + CW)
        && ({2'b00, rival_y} < {2'b00, car_y} + CH)
        && ({2'b00, car_y} < {2'b00, rival_y} + CH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state            <= S_WAIT;
            r_tick_cnt         <= '0;
            r_delay            <= '0;
            r_lfsr             <= LFSR_SEED;
            rival_x            <= '0;
            rival_y            <= SPAWN_Y;
            rival_active       <= 1'b0;
            collide_with_rival <= 1'b0;
            score              <= '0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
            if (restart) begin
                r_state            <= S_WAIT;
                r_tick_cnt         <= '0;
                r_delay            <= '0;
                rival_y            <= SPAWN_Y;
                rival_active       <= 1'b0;
                collide_with_rival <= 1'b0;
                score              <= '0;
            end else begin
                r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
                unique case (r_state)
                    S_WAIT: begin
                        if (w_tick) begin
                            if (r_delay == DW'(RESPAWN_DELAY - 1)) begin
                                r_delay <= '0;
                                r_state <= S_SPAWN;
                            end else begin
                                r_delay <= r_delay + DW'(1);
                            end
                        end
                    end
                    S_SPAWN: begin
                        rival_x      <= w_lane_x;
                        rival_y      <= SPAWN_Y;
                        rival_active <= 1'b1;
                        r_state      <= S_DRIVE;
                    end
                    S_DRIVE: begin
                        // A crash on the exit tick wins; the rival is not scored.
                        if (w_overlap) begin
                            collide_with_rival <= 1'b1;
                            r_state            <= S_CRASH;
                        end else if (w_tick && bg_sp_y) begin
                            if (w_exit) begin
                                rival_active <= 1'b0;
                                score        <= score + 16'd1;
                                r_state      <= S_WAIT;
                            end else begin
                                rival_y <= w_next_y[8:0];
                            end
                        end
                    end
                    S_CRASH: begin
                        collide_with_rival <= 1'b1;
                    end
                    default: r_state <= S_WAIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rival_car_gen.sv
// Directed testbench for rival_car_gen: spawn, traversal, overlap table, restart, reset.
// Build with RIVAL_SPEEDUP_EN defined to also exercise the speed-up steps.
module tb_rival_car_gen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        restart = 1'b0;
    logic [9:0]  car_x = '0;
    logic [8:0]  car_y = '0;
    logic        bg_sp_y = 1'b0;
    logic [9:0]  rival_x;
    logic [8:0]  rival_y;
    logic        rival_active;
    logic        collide_with_rival;
    logic [15:0] score;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rival_car_gen #(
        .STEP_DIV      (4),
        .RESPAWN_DELAY (2),
        .BG_HEIGHT     (20)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .restart            (restart),
        .car_x              (car_x),
        .car_y              (car_y),
        .bg_sp_y            (bg_sp_y),
        .rival_x            (rival_x),
        .rival_y            (rival_y),
        .rival_active       (rival_active),
        .collide_with_rival (collide_with_rival),
        .score              (score)
    );

    // Reference LFSR: m is the live state, used is the value seen at the last edge.
    logic [15:0] m_lfsr;
    logic [15:0] used_lfsr;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_lfsr    <= 16'hACE1;
            used_lfsr <= 16'hACE1;
        end else begin
            used_lfsr <= m_lfsr;
            m_lfsr    <= {m_lfsr[14:0],
                          m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    function automatic int lane_of(input logic [15:0] l);
        case (l[1:0])
            2'd0:    return 248;
            2'd2:    return 300;
            default: return 274;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_act(input logic lvl, input int maxc, output int n);
        n = 0;
        while (rival_active !== lvl && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_y_change(input int maxc, output int n);
        logic [8:0] y0;
        y0 = rival_y;
        n = 0;
        while (rival_y === y0 && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_score(input int t, input int maxc);
        int n;
        n = 0;
        while (int'(score) != t && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("score_reach", int'(score), t);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        step_n(1);
        restart = 1'b0;
    endtask

    typedef struct {
        int dx;
        int dy;
        int exp;
    } ovl_vec_t;

    ovl_vec_t vecs[10];

    initial begin
        int n;
        int bad;
        logic [8:0] y0;
        logic [9:0] x0;

        vecs[0] = '{13, 0, 1};
        vecs[1] = '{14, 0, 0};
        vecs[2] = '{-13, 0, 1};
        vecs[3] = '{-14, 0, 0};
        vecs[4] = '{0, 15, 1};
        vecs[5] = '{0, 16, 0};
        vecs[6] = '{0, -15, 1};
        vecs[7] = '{0, -16, 0};
        vecs[8] = '{13, 15, 1};
        vecs[9] = '{14, 16, 0};

        // Reset state
        bg_sp_y = 1'b1;
        step_n(3);
        chk("rst_x", int'(rival_x), 0);
        chk("rst_y", int'(rival_y), 150);
        chk("rst_active", int'(rival_active), 0);
        chk("rst_collide", int'(collide_with_rival), 0);
        chk("rst_score", int'(score), 0);
        reset_n = 1'b1;

        // First spawn: 2 ticks of 4 clocks, then SPAWN, then active
        wait_act(1'b1, 30, n);
        chk("spawn_latency", n, 9);
        chk("spawn_lane", int'(rival_x), lane_of(used_lfsr));
        chk("spawn_y", int'(rival_y), 150);

        // Traversal 150..168 then exit
        for (int k = 1; k <= 9; k++) begin
            wait_y_change(8, n);
            chk($sformatf("move%0d", k), int'(rival_y), 150 + 2 * k);
        end
        wait_act(1'b0, 8, n);
        chk("exit_active", int'(rival_active), 0);
        chk("exit_score", int'(score), 1);
        chk("exit_y_hold", int'(rival_y), 168);
        wait_act(1'b1, 30, n);
        chk("respawn_latency", n, 9);
        chk("respawn_lane", int'(rival_x), lane_of(used_lfsr));

        // Freeze with scrolling stopped
        bg_sp_y = 1'b0;
        y0 = rival_y;
        bad = 0;
        repeat (20) begin
            step_n(1);
            if (rival_y !== y0 || collide_with_rival !== 1'b0) bad++;
        end
        chk("freeze", bad, 0);

        // Reach score 3, then collide at the X boundary
        bg_sp_y = 1'b1;
        wait_score(3, 400);
        wait_act(1'b1, 30, n);
        bg_sp_y = 1'b0;
        car_y = rival_y;
        car_x = rival_x + 10'd14;
        step_n(3);
        chk("no_col_dx14", int'(collide_with_rival), 0);
        car_x = rival_x + 10'd13;
        step_n(1);
        chk("col_dx13", int'(collide_with_rival), 1);
        y0 = rival_y;
        x0 = rival_x;
        bg_sp_y = 1'b1;
        step_n(12);
        chk("crash_y_hold", int'(rival_y), int'(y0));
        chk("crash_active", int'(rival_active), 1);
        chk("crash_collide", int'(collide_with_rival), 1);
        chk("crash_score", int'(score), 3);

        // Single-cycle restart out of CRASH
        car_x = '0;
        car_y = '0;
        pulse_restart();
        chk("rs_collide", int'(collide_with_rival), 0);
        chk("rs_score", int'(score), 0);
        chk("rs_active", int'(rival_active), 0);
        chk("rs_y", int'(rival_y), 150);
        chk("rs_x_hold", int'(rival_x), int'(x0));
        wait_act(1'b1, 30, n);
        chk("rs_spawn_latency", n, 9);

        // Overlap table, each from a fresh spawn with the rival frozen
        for (int i = 0; i < 10; i++) begin
            bg_sp_y = 1'b0;
            car_x = '0;
            car_y = '0;
            pulse_restart();
            wait_act(1'b1, 30, n);
            chk($sformatf("ovl%0d_lane", i), int'(rival_x), lane_of(used_lfsr));
            car_x = 10'(int'(rival_x) + vecs[i].dx);
            car_y = 9'(int'(rival_y) + vecs[i].dy);
            step_n(2);
            chk($sformatf("ovl%0d", i), int'(collide_with_rival), vecs[i].exp);
        end

        // Asynchronous reset mid-DRIVE
        car_x = '0;
        car_y = '0;
        bg_sp_y = 1'b1;
        step_n(5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_x", int'(rival_x), 0);
        chk("arst_y", int'(rival_y), 150);
        chk("arst_active", int'(rival_active), 0);
        chk("arst_collide", int'(collide_with_rival), 0);
        chk("arst_score", int'(score), 0);
        step_n(1);
        reset_n = 1'b1;

`ifdef RIVAL_SPEEDUP_EN
        wait_score(8, 3000);
        wait_act(1'b1, 30, n);
        wait_y_change(8, n);
        chk("speed_step3", int'(rival_y), 153);
        wait_score(24, 6000);
        wait_act(1'b1, 30, n);
        wait_y_change(8, n);
        chk("speed_step4_cap", int'(rival_y), 154);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rival_car_gen.md
# rival_car_gen

Spawns and drives the single rival car down the road, detects bounding-box overlap with the player car, and counts rivals passed. Sits directly upstream of `car_fsm`: consumes the player's `car_x`/`car_y` and the `bg_sp_y` scroll flag, and produces the `collide_with_rival` input that `car_fsm` uses to enter COLLIDE. Its `rival_x`/`rival_y`/`rival_active` outputs feed the sprite renderer.

## Interface
- OFFSET_BG_X, 200, background left edge in screen pixels
- OFFSET_BG_Y, 150, background top edge; this is the rival spawn Y (SPAWN_Y)
- BG_HEIGHT, 240, background height; EXIT_Y = OFFSET_BG_Y + BG_HEIGHT
- CAR_WIDTH, 14, sprite width for both cars
- CAR_HEIGHT, 16, sprite height for both cars
- ROAD_LEFT, 44, road left edge relative to OFFSET_BG_X
- RIVAL_STEP, 2, pixels moved per move tick
- STEP_DIV, 1_000_000, clocks per move tick
- RESPAWN_DELAY, 32, move ticks between a rival exiting and the next spawn
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

- clk  in  1  system clock, 100 MHz
- reset_n  in  1  asynchronous, active-low reset
- restart  in  1  synchronous restart, debounced BTNC level
- car_x  in  10  player top-left X
- car_y  in  9  player top-left Y
- bg_sp_y  in  1  1 = road scrolling; rival moves only while high
- rival_x  out  10  rival top-left X
- rival_y  out  9  rival top-left Y
- rival_active  out  1  rival on road, must be drawn
- collide_with_rival  out  1  sticky overlap flag, to car_fsm
- score  out  16  rivals passed since reset/restart

## Operation
- Reset values: rival_x=0, rival_y=OFFSET_BG_Y, rival_active=0, collide_with_rival=0, score=0, state=WAIT, tick counter=0, delay counter=0, LFSR=LFSR_SEED.
- Tick counter counts 0..STEP_DIV-1. `tick` is a 1-cycle pulse when it wraps.
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, advances every clock and is never cleared by restart.
- Lane select: lfsr[1:0] gives 0→lane0, 1→lane1, 2→lane2, 3→lane1. Lane X = OFFSET_BG_X+ROAD_LEFT+{4,30,56}.
- The FSM has four states:
  - WAIT: on each tick, increment the delay counter. When the counter reaches RESPAWN_DELAY, clear it and go to SPAWN.
  - SPAWN (1 cycle): latch rival_x from lane select, set rival_y=SPAWN_Y and rival_active=1, then go to DRIVE.
  - DRIVE: on tick with bg_sp_y=1:
    - If rival_y+step ≥ EXIT_Y (computed at 10 bits), set rival_active=0, increment score (wraps at 16 bits) and go to WAIT.
    - Otherwise, rival_y += step.
  - CRASH: outputs hold and collide_with_rival=1. Exit only via restart.
- Overlap is combinational and is evaluated only in DRIVE. It is true when all four hold: rival_x < car_x+CAR_WIDTH, car_x < rival_x+CAR_WIDTH, rival_y < car_y+CAR_HEIGHT, car_y < rival_y+CAR_HEIGHT. Sums are computed at 11 bits.
- Overlap in DRIVE sets collide_with_rival=1 and moves the FSM to CRASH on the next edge. This is independent of tick and bg_sp_y.
- Priority order: reset_n > restart > overlap > exit/move.
  - Overlap and exit on the same tick: the crash wins and score is unchanged.
- restart=1, every cycle it is held: state=WAIT, both counters=0, rival_active=0, rival_y=SPAWN_Y, collide_with_rival=0, score=0. rival_x holds its value.

## Timing
- All outputs are registered.
- collide_with_rival rises 1 clock after the first overlapping cycle.
- Spawn occurs 1 clock after the RESPAWN_DELAY-th tick in WAIT. rival_active rises the clock after that.
- Position updates land 1 clock after tick.
- With bg_sp_y=0, the tick counter keeps running but the rival does not move. WAIT still counts ticks.
- Asserting reset_n low mid-operation forces reset values immediately (asynchronous). Release is synchronous to clk.
- restart held for N cycles gives N cycles of restart state. Normal operation resumes on the first cycle with restart=0.

## Configuration
- RIVAL_SPEEDUP_EN defined: the effective step is min(RIVAL_STEP + score[15:3], 4), i.e. +1 px every 8 rivals passed, capped at 4. Both the exit compare and the move use the effective step.
- RIVAL_SPEEDUP_EN undefined: the step is the constant RIVAL_STEP and no speed-up logic is built.

## Test plan
Bench parameters for all scenarios: STEP_DIV=4, RESPAWN_DELAY=2, BG_HEIGHT=20.
- Spawn/lane: hold reset_n=0 for 3 cycles, release, player parked at car_x=0 → rival_active=1 after 2 ticks + 2 clocks. rival_x ∈ {248, 274, 300} and matches the lane mapping of the observed LFSR state.
- Traversal/score: no overlap, bg_sp_y=1 → rival_y steps 150, 152, …, 168, then exits (168+2 ≥ 170). rival_active=0 and score=1. Next spawn follows 2 ticks later.
- Collision: car_x=rival_x+13 with car_y inside the rival's Y span → collide_with_rival=1 one clock later, FSM in CRASH, rival frozen. With car_x=rival_x+14 → no collision.
- Freeze: bg_sp_y=0 in DRIVE for 20 clocks → rival_y is constant and collide_with_rival stays 0.
- Restart/reset: from CRASH with score=3, pulse restart for 1 cycle → collide_with_rival=0, score=0, rival_active=0, state WAIT. Then assert reset_n=0 mid-DRIVE → all outputs reach reset values before the next edge.
- Config: with RIVAL_SPEEDUP_EN defined and score forced past 8 → step of 3 px observed. With 24 rivals passed, step is capped at 4.
